control_sequencer: RTL

//  Hard-wired fetch/decode/execute controller for the ALU system datapath.

---
 rtl/control_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute control sequencer for the ALU system datapath
// Fetches a 16-bit instruction as two bytes, then decodes ALU/LDI/BR/ST/HALT into datapath controls.

module control_sequencer #(
  parameter int MEM_WAIT = 0,
  parameter bit WF_EN    = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  Flags,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [1:0]  MuxCSel,
  output logic        MuxDSel,
  output logic [1:0]  DR_FunSel,
  output logic        DR_E,
  output logic        Halted
);

  typedef enum logic [2:0] {
    S_FL   = 3'd0,
    S_FH   = 3'd1,
    S_EX0  = 3'd2,
    S_EX1  = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT);

  state_t     state, state_nx;
  logic [1:0] wait_cnt, wait_nx;
  logic       mem_done;
  logic       is_store;
  logic       br_taken;
  logic       unused_bits;

  assign mem_done    = (wait_cnt == WAIT_LAST);
  assign is_store    = (state == S_EX1) || (state == S_EX0 && IROut[15:13] == 3'b110);
  assign unused_bits = ^{IROut[3], Flags[1:0]};

  // Flags are {Z,C,N,O}
  always_comb begin
    case (IROut[9:8])
      2'b00:   br_taken = 1'b1;
      2'b01:   br_taken = Flags[3];
      2'b10:   br_taken = ~Flags[3];
      default: br_taken = Flags[2];
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= S_FL;
      wait_cnt <= 2'd0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  always_comb begin
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 3'b000;
    RF_RegSel   = 4'b0000;
    RF_ScrSel   = 4'b0000;
    ALU_FunSel  = 5'b00000;
    ALU_WF      = 1'b0;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 3'b000;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 2'b00;
    MuxDSel     = 1'b0;
    DR_FunSel   = 2'b00;
    DR_E        = 1'b0;
    Halted      = 1'b0;
    state_nx    = state;
    wait_nx     = wait_cnt;

    // Reset gates outputs combinationally so an abandoned access deasserts in the same cycle
    if (Reset) begin
      case (state)
        S_FL, S_FH: begin
          Mem_CS = 1'b0;
          IR_LH  = (state == S_FH);
          if (mem_done) begin
            IR_Write   = 1'b1;
            ARF_FunSel = 2'b01;
            ARF_RegSel = 3'b100;
            wait_nx    = 2'd0;
            state_nx   = (state == S_FL) ? S_FH : S_EX0;
          end else begin
            wait_nx = wait_cnt + 2'd1;
          end
        end
        S_EX0: begin
          case (IROut[15:14])
            2'b00: begin
              ALU_FunSel = IROut[13:9];
              RF_OutASel = IROut[6:4];
              RF_OutBSel = IROut[2:0];
              RF_FunSel  = 3'b010;
              RF_RegSel  = 4'b1000 >> IROut[8:7];
              ALU_WF     = WF_EN;
              state_nx   = S_FL;
            end
            2'b01: begin
              MuxASel   = 2'b11;
              RF_FunSel = 3'b010;
              RF_RegSel = 4'b1000 >> IROut[9:8];
              state_nx  = S_FL;
            end
            2'b10: begin
              if (br_taken) begin
                MuxBSel    = 2'b11;
                ARF_FunSel = 2'b10;
                ARF_RegSel = 3'b100;
              end
              state_nx = S_FL;
            end
            default: begin
              if (IROut[13]) state_nx = S_HALT;
              else if (mem_done) state_nx = S_EX1;
            end
          endcase
        end
        S_EX1:   if (mem_done) state_nx = S_FL;
        S_HALT:  Halted = 1'b1;
        default: state_nx = S_FL;
      endcase

      // Store: low byte in S_EX0, high byte in S_EX1, AR post-incremented after each byte
      if (is_store) begin
        RF_OutASel  = IROut[6:4];
        MuxDSel     = 1'b0;
        ALU_FunSel  = 5'b10000;
        ARF_OutDSel = 2'b10;
        Mem_CS      = 1'b0;
        Mem_WR      = 1'b1;
        MuxCSel     = (state == S_EX1) ? 2'b01 : 2'b00;
        if (mem_done) begin
          ARF_FunSel = 2'b01;
          ARF_RegSel = 3'b010;
          wait_nx    = 2'd0;
        end else begin
          wait_nx = wait_cnt + 2'd1;
        end
      end
    end
  end

endmodule
